uart_apb_master: RTL

//  Single-outstanding APB3 master bridge that sits directly upstream of uart_top's APB3 slave port.

---
 rtl/uart_apb_master_if.sv | 44 ++++
 rtl/uart_apb_master.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/uart_apb_master_if.sv
// Command, response and APB3 signals of the uart_apb_master bridge, named from the bridge's side.
// master modport: the bridge itself. slave modport: the sequencer and APB slave around it.
// No logic here; all timing lives in uart_apb_master.
interface uart_apb_master_if #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32
);
  // command stream
  logic                      i_cmd_valid;
  logic                      o_cmd_ready;
  logic                      i_cmd_write;
  logic [APB_ADDR_WIDTH-1:0] i_cmd_addr;
  logic [APB_DATA_WIDTH-1:0] i_cmd_wdata;
  // response stream
  logic                      o_rsp_valid;
  logic                      i_rsp_ready;
  logic [APB_DATA_WIDTH-1:0] o_rsp_rdata;
  logic                      o_rsp_err;
  logic                      o_rsp_timeout;
  logic                      o_busy;
  // APB3 bus
  logic [APB_ADDR_WIDTH-1:0] o_apb_paddr;
  logic [APB_DATA_WIDTH-1:0] o_apb_pwdata;
  logic                      o_apb_pwrite;
  logic                      o_apb_psel;
  logic                      o_apb_penable;
  logic [APB_DATA_WIDTH-1:0] i_apb_prdata;
  logic                      i_apb_pready;
  logic                      i_apb_pslverr;

  modport master (
    input  i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_wdata, i_rsp_ready,
    input  i_apb_prdata, i_apb_pready, i_apb_pslverr,
    output o_cmd_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_timeout, o_busy,
    output o_apb_paddr, o_apb_pwdata, o_apb_pwrite, o_apb_psel, o_apb_penable
  );

  modport slave (
    output i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_wdata, i_rsp_ready,
    output i_apb_prdata, i_apb_pready, i_apb_pslverr,
    input  o_cmd_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_timeout, o_busy,
    input  o_apb_paddr, o_apb_pwdata, o_apb_pwrite, o_apb_psel, o_apb_penable
  );
endinterface

// File: rtl/uart_apb_master.sv
// Purpose: single-outstanding APB3 master turning a valid/ready command stream into SETUP/ACCESS phases.
// Latency: cmd accepted at edge N -> PSEL sampled N+1 -> PENABLE N+2 -> earliest rsp_valid N+3.
// Backpressure: cmd_ready only in IDLE; response held until rsp_ready; PREADY stretches ACCESS.
// Optional watchdog: define APB_MASTER_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES cycles.
module uart_apb_master #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic                i_apb_pclk,
  input logic                i_apb_preset,
  uart_apb_master_if.master  bus
);

  localparam int AW = APB_ADDR_WIDTH;
  localparam int DW = APB_DATA_WIDTH;

  // Reject an unusable watchdog length at elaboration.
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("uart_apb_master: TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t          state_q,     state_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            busy_q,      busy_d;
  logic [AW-1:0]   paddr_q,     paddr_d;
  logic [DW-1:0]   pwdata_q,    pwdata_d;
  logic            pwrite_q,    pwrite_d;
  logic            psel_q,      psel_d;
  logic            penable_q,   penable_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q,   rsp_err_d;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0]   timer_q,     timer_d;
  logic            rsp_tmo_q,   rsp_tmo_d;
`endif

  // Next-state and next-output computation for the whole bridge.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    busy_d      = busy_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
    timer_d     = timer_q;
    rsp_tmo_d   = rsp_tmo_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_cmd_valid && cmd_ready_q) begin
          paddr_d     = bus.i_cmd_addr;
          pwrite_d    = bus.i_cmd_write;
          // Reads drive zero on PWDATA so stale write data never leaks onto the bus.
          pwdata_d    = bus.i_cmd_write ? bus.i_cmd_wdata : '0;
          psel_d      = 1'b1;
          penable_d   = 1'b0;
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = ST_SETUP;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
        timer_d   = '0;
`endif
      end
      ST_ACCESS: begin
        // A PREADY on the final watchdog cycle still counts as a normal completion.
        if (bus.i_apb_pready) begin
          rsp_rdata_d = pwrite_q ? '0 : bus.i_apb_prdata;
          rsp_err_d   = bus.i_apb_pslverr;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
`ifdef APB_MASTER_TIMEOUT_EN
          rsp_tmo_d   = 1'b0;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_tmo_d   = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          timer_d     = timer_q + TW'(1);
`endif
        end
      end
      ST_RESP: begin
        if (bus.i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register; reset drops any transfer in flight without a response.
  always_ff @(posedge i_apb_pclk) begin
    if (i_apb_preset) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      timer_q     <= '0;
      rsp_tmo_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef APB_MASTER_TIMEOUT_EN
      timer_q     <= timer_d;
      rsp_tmo_q   <= rsp_tmo_d;
`endif
    end
  end

  assign bus.o_cmd_ready   = cmd_ready_q;
  assign bus.o_busy        = busy_q;
  assign bus.o_apb_paddr   = paddr_q;
  assign bus.o_apb_pwdata  = pwdata_q;
  assign bus.o_apb_pwrite  = pwrite_q;
  assign bus.o_apb_psel    = psel_q;
  assign bus.o_apb_penable = penable_q;
  assign bus.o_rsp_valid   = rsp_valid_q;
  assign bus.o_rsp_rdata   = rsp_rdata_q;
  assign bus.o_rsp_err     = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
  assign bus.o_rsp_timeout = rsp_tmo_q;
`else
  assign bus.o_rsp_timeout = 1'b0;
`endif

endmodule
